status_flag_unit: RTL and testbench
===================================

Name: status_flag_unit

Overview:
- Owns the architectural NZCV status register and its saved copy for exceptions.
- Commits flag updates from the EXE stage and explicit flag writes. Saves and restores flags across one exception level.
- Supplies ID-stage flags (z, c, v, n) to the condition-check logic. Raises a hazard stall when those flags would be stale.

Parameters:
- ALWAYS_COND, 4'b1110, condition code that never needs flags (never causes a hazard).
- NV_COND, 4'b1111, unimplemented condition, treated as always (never causes a hazard).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- freeze  in  1  pipeline stall; all state holds while high.
- exe_valid  in  1  EXE stage holds a real instruction.
- exe_s  in  1  S bit of EXE instruction (sets flags).
- exe_flags  in  4  {n,z,c,v} produced by the ALU this cycle.
- msr_we  in  1  explicit flag write.
- msr_flags  in  4  {n,z,c,v} for explicit write.
- exc_entry  in  1  exception taken.
- exc_return  in  1  return from exception.
- id_valid  in  1  ID stage holds a real instruction.
- id_cond  in  4  condition field of ID instruction.
- z, c, v, n  out  1 each  flags delivered to ID condition check.
- flags_q  out  4  committed {n,z,c,v}.
- spsr_q  out  4  saved {n,z,c,v}.
- in_exc  out  1  exception-mode state bit.
- flag_hazard  out  1  ID must stall this cycle.
- proto_err  out  1  one-cycle pulse after an illegal exception event.

Behaviour:
- Reset (rst=0, async): flags_q=0, spsr_q=0, in_exc=0, proto_err=0.
- Update sources:
  - upd_exe = exe_valid & exe_s.
  - nxt = msr_we ? msr_flags : (upd_exe ? exe_flags : flags_q). msr_we wins over EXE.
- Rising edge with freeze=0, first matching rule applies:
  1. exc_return & in_exc: flags_q<=spsr_q, in_exc<=0. Pending msr/EXE updates are discarded.
  2. exc_entry & ~in_exc: spsr_q<=nxt, flags_q<=nxt, in_exc<=1. The same-cycle update is preserved in both registers.
  3. Otherwise: flags_q<=nxt.
- Exception-mode FSM has two states:
  - NORMAL(in_exc=0): exc_entry -> EXC.
  - EXC(in_exc=1): exc_return -> NORMAL.
- Illegal exception events:
  - exc_entry in EXC (nested) or exc_return in NORMAL is ignored. The state does not change.
  - That edge sets proto_err=1 for exactly one cycle, then it clears.
  - exc_entry and exc_return in the same cycle: rule order applies. In EXC, the return wins. In NORMAL, the entry wins and no error is raised.
- freeze=1: all registers hold. EXE/msr/exception inputs are ignored that cycle, because the pipeline re-presents them. proto_err clears.
- The ID flag outputs (z,c,v,n) are combinational. Their source depends on the optional feature.
- Latency: a committed update is visible on flags_q one cycle after the edge.

Optional Feature:
- Macro: STATUS_FLAG_BYPASS_EN.
- Defined:
  - {n,z,c,v} outputs = nxt (same-cycle bypass from EXE/msr).
  - flag_hazard is tied 0.
- Undefined:
  - {n,z,c,v} outputs = flags_q.
  - flag_hazard = id_valid & (id_cond!=ALWAYS_COND) & (id_cond!=NV_COND) & (upd_exe | msr_we).
- In both builds, during exc_return in EXC the bypass/hazard still reflect nxt. The ID instruction is flushed by the exception logic in that case.

Test Plan:
1. Reset then exe_valid=1, exe_s=1, exe_flags=4'b0100 for 1 cycle -> flags_q=4'b0100 next cycle. With bypass, z=1 in the same cycle. Without bypass and id_cond=4'b0000 with id_valid=1, flag_hazard=1 in that cycle.
2. msr_we=1, msr_flags=4'b1001 together with upd_exe carrying 4'b0010 -> flags_q=4'b1001 (msr wins).
3. flags_q=4'b0010, exc_entry with upd_exe=4'b1000 -> spsr_q=4'b1000, in_exc=1. Then upd_exe=4'b0001 gives flags_q=4'b0001. Then exc_return -> flags_q=4'b1000, in_exc=0.
4. In EXC, pulse exc_entry -> spsr_q unchanged, proto_err=1 for exactly one cycle. In NORMAL, pulse exc_return -> proto_err pulse, flags unchanged.
5. freeze=1 with upd_exe=4'b1111 and exc_entry -> no state change. Release freeze with the same inputs -> update and entry take effect.
6. Assert rst low mid-operation (in_exc=1, flags_q=4'b1010) between edges -> all outputs 0 immediately. id_cond=4'b1110 never raises flag_hazard.

Source files
------------

// File: rtl/status_flag_unit_if.sv
// ============================================================================
// Module   : status_flag_unit_if
// Brief    : Pipeline-side bundle of the NZCV status flag unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface status_flag_unit_if;
  logic       freeze;
  logic       exe_valid;
  logic       exe_s;
  logic [3:0] exe_flags;
  logic       msr_we;
  logic [3:0] msr_flags;
  logic       exc_entry;
  logic       exc_return;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       z;
  logic       c;
  logic       v;
  logic       n;
  logic [3:0] flags_q;
  logic [3:0] spsr_q;
  logic       in_exc;
  logic       flag_hazard;
  logic       proto_err;

  modport master (
    output freeze, exe_valid, exe_s, exe_flags, msr_we, msr_flags,
           exc_entry, exc_return, id_valid, id_cond,
    input  z, c, v, n, flags_q, spsr_q, in_exc, flag_hazard, proto_err
  );

  modport slave (
    input  freeze, exe_valid, exe_s, exe_flags, msr_we, msr_flags,
           exc_entry, exc_return, id_valid, id_cond,
    output z, c, v, n, flags_q, spsr_q, in_exc, flag_hazard, proto_err
  );
endinterface

`default_nettype wire

// File: rtl/status_flag_unit.sv
// ============================================================================
// Module   : status_flag_unit
// Brief    : Architectural NZCV register, exception save/restore, ID flags.
//            Optional macro STATUS_FLAG_BYPASS_EN forwards next flags to ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module status_flag_unit #(
  parameter logic [3:0] ALWAYS_COND = 4'b1110,
  parameter logic [3:0] NV_COND     = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  status_flag_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    EXC    = 1'b1
  } exc_state_t;

  exc_state_t state;
  logic [3:0] flags_reg;
  logic [3:0] spsr_reg;
  logic       proto_err_reg;
  logic       upd_exe;
  logic [3:0] nxt;

  always_comb begin
    upd_exe = bus.exe_valid & bus.exe_s;
    nxt     = flags_reg;
    if (bus.msr_we)
      nxt = bus.msr_flags;
    else if (upd_exe)
      nxt = bus.exe_flags;
  end

  // proto_err is a one-shot: it defaults low every edge, including frozen ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= NORMAL;
      flags_reg     <= 4'b0000;
      spsr_reg      <= 4'b0000;
      proto_err_reg <= 1'b0;
    end else begin
      proto_err_reg <= 1'b0;
      if (!bus.freeze) begin
        case (state)
          NORMAL: begin
            if (bus.exc_entry) begin
              spsr_reg  <= nxt;
              flags_reg <= nxt;
              state     <= EXC;
            end else begin
              flags_reg <= nxt;
              if (bus.exc_return)
                proto_err_reg <= 1'b1;
            end
          end
          EXC: begin
            if (bus.exc_return) begin
              flags_reg <= spsr_reg;
              state     <= NORMAL;
            end else begin
              flags_reg <= nxt;
              if (bus.exc_entry)
                proto_err_reg <= 1'b1;
            end
          end
          default: state <= NORMAL;
        endcase
      end
    end
  end

  assign bus.flags_q   = flags_reg;
  assign bus.spsr_q    = spsr_reg;
  assign bus.in_exc    = (state == EXC);
  assign bus.proto_err = proto_err_reg;

`ifdef STATUS_FLAG_BYPASS_EN
  assign {bus.n, bus.z, bus.c, bus.v} = nxt;
  assign bus.flag_hazard              = 1'b0;
`else
  assign {bus.n, bus.z, bus.c, bus.v} = flags_reg;
  assign bus.flag_hazard = bus.id_valid
                         & (bus.id_cond != ALWAYS_COND)
                         & (bus.id_cond != NV_COND)
                         & (upd_exe | bus.msr_we);
`endif

endmodule

`default_nettype wire

// File: tb/tb_status_flag_unit.sv
// ============================================================================
// Module   : tb_status_flag_unit
// Brief    : Directed scoreboard bench for status_flag_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_status_flag_unit;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic [3:0] spsr;
    logic       in_exc;
    logic       perr;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  status_flag_unit_if bus ();

  status_flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.freeze     = 1'b0;
    bus.exe_valid  = 1'b0;
    bus.exe_s      = 1'b0;
    bus.exe_flags  = 4'b0000;
    bus.msr_we     = 1'b0;
    bus.msr_flags  = 4'b0000;
    bus.exc_entry  = 1'b0;
    bus.exc_return = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_cond    = 4'b0000;
  endtask

  task automatic exe(input logic [3:0] f);
    bus.exe_valid = 1'b1;
    bus.exe_s     = 1'b1;
    bus.exe_flags = f;
  endtask

  // Push expected post-edge state, clock once, pop and compare.
  task automatic tick(input string tag, input logic [3:0] ef, input logic [3:0] es,
                      input logic ei, input logic ep);
    exp_t e;
    exp_t got;
    e.tag = tag; e.flags = ef; e.spsr = es; e.in_exc = ei; e.perr = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.tag, ".flags"},  {4'b0, bus.flags_q}, {4'b0, got.flags});
    chk({got.tag, ".spsr"},   {4'b0, bus.spsr_q},  {4'b0, got.spsr});
    chk({got.tag, ".in_exc"}, {7'b0, bus.in_exc},  {7'b0, got.in_exc});
    chk({got.tag, ".perr"},   {7'b0, bus.proto_err}, {7'b0, got.perr});
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.flags", {4'b0, bus.flags_q}, 8'h00);
    chk("reset.spsr",  {4'b0, bus.spsr_q},  8'h00);
    chk("reset.state", {6'b0, bus.in_exc, bus.proto_err}, 8'h00);
    rst = 1'b1;

    // 1: EXE flag update, same-cycle bypass or hazard
    exe(4'b0100);
    bus.id_valid = 1'b1;
    bus.id_cond  = 4'b0000;
    #1;
`ifdef STATUS_FLAG_BYPASS_EN
    chk("t1.z_same",   {7'b0, bus.z},           8'h01);
    chk("t1.hazard",   {7'b0, bus.flag_hazard}, 8'h00);
`else
    chk("t1.z_same",   {7'b0, bus.z},           8'h00);
    chk("t1.hazard",   {7'b0, bus.flag_hazard}, 8'h01);
`endif
    tick("t1", 4'b0100, 4'b0000, 1'b0, 1'b0);
    chk("t1.z_after", {7'b0, bus.z}, 8'h01);

    // 2: msr wins over EXE; AL condition never hazards
    bus.msr_we    = 1'b1;
    bus.msr_flags = 4'b1001;
    exe(4'b0010);
    bus.id_valid = 1'b1;
    bus.id_cond  = 4'b1110;
    #1;
    chk("t2.hazard_al", {7'b0, bus.flag_hazard}, 8'h00);
`ifdef STATUS_FLAG_BYPASS_EN
    chk("t2.nzcv_same", {4'b0, bus.n, bus.z, bus.c, bus.v}, 8'h09);
`else
    chk("t2.nzcv_same", {4'b0, bus.n, bus.z, bus.c, bus.v}, 8'h04);
`endif
    tick("t2", 4'b1001, 4'b0000, 1'b0, 1'b0);

    // 3: entry keeps the same-cycle update, return restores and discards
    exe(4'b0010);
    tick("t3.pre",   4'b0010, 4'b0000, 1'b0, 1'b0);
    exe(4'b1000);
    bus.exc_entry = 1'b1;
    tick("t3.entry", 4'b1000, 4'b1000, 1'b1, 1'b0);
    exe(4'b0001);
    tick("t3.inexc", 4'b0001, 4'b1000, 1'b1, 1'b0);
    exe(4'b0110);
    bus.exc_return = 1'b1;
    tick("t3.ret",   4'b1000, 4'b1000, 1'b0, 1'b0);

    // 4: illegal events pulse proto_err for one cycle
    bus.exc_entry = 1'b1;
    tick("t4.entry",  4'b1000, 4'b1000, 1'b1, 1'b0);
    exe(4'b0011);
    bus.exc_entry = 1'b1;
    tick("t4.nested", 4'b0011, 4'b1000, 1'b1, 1'b1);
    tick("t4.clear",  4'b0011, 4'b1000, 1'b1, 1'b0);
    bus.exc_return = 1'b1;
    tick("t4.ret",    4'b1000, 4'b1000, 1'b0, 1'b0);
    bus.exc_return = 1'b1;
    tick("t4.badret", 4'b1000, 4'b1000, 1'b0, 1'b1);
    tick("t4.clear2", 4'b1000, 4'b1000, 1'b0, 1'b0);
    exe(4'b0101);
    bus.exc_entry  = 1'b1;
    bus.exc_return = 1'b1;
    tick("t4.both_norm", 4'b0101, 4'b0101, 1'b1, 1'b0);
    exe(4'b1100);
    bus.exc_entry  = 1'b1;
    bus.exc_return = 1'b1;
    tick("t4.both_exc",  4'b0101, 4'b0101, 1'b0, 1'b0);

    // 5: freeze holds state and clears a pending proto_err
    bus.exc_return = 1'b1;
    tick("t5.badret", 4'b0101, 4'b0101, 1'b0, 1'b1);
    bus.freeze    = 1'b1;
    exe(4'b1111);
    bus.exc_entry = 1'b1;
    tick("t5.frozen", 4'b0101, 4'b0101, 1'b0, 1'b0);
    exe(4'b1111);
    bus.exc_entry = 1'b1;
    tick("t5.release", 4'b1111, 4'b1111, 1'b1, 1'b0);

    // 6: async reset mid-operation
    exe(4'b1010);
    tick("t6.pre", 4'b1010, 4'b1111, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.flags", {4'b0, bus.flags_q}, 8'h00);
    chk("t6.spsr",  {4'b0, bus.spsr_q},  8'h00);
    chk("t6.state", {6'b0, bus.in_exc, bus.proto_err}, 8'h00);
    chk("t6.nzcv",  {4'b0, bus.n, bus.z, bus.c, bus.v}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    exe(4'b0110);
    bus.id_valid = 1'b1;
    bus.id_cond  = 4'b1110;
    #1;
    chk("t6.hazard_al", {7'b0, bus.flag_hazard}, 8'h00);
    bus.id_cond = 4'b1111;
    #1;
    chk("t6.hazard_nv", {7'b0, bus.flag_hazard}, 8'h00);
    bus.id_cond  = 4'b0001;
    bus.id_valid = 1'b0;
    #1;
    chk("t6.hazard_noid", {7'b0, bus.flag_hazard}, 8'h00);
    tick("t6.post", 4'b0110, 4'b0000, 1'b0, 1'b0);

    chk("sb.empty", sb.size() == 0 ? 8'h01 : 8'h00, 8'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
